// File: rtl/regfile_sequencer.sv
// Register-file front-end: clears every register after reset, passes datapath
// writes through, and on request streams all registers out on the dump port.
module regfile_sequencer #(
    parameter int unsigned REGFILE_WIDTH   = 3,
    parameter int unsigned DATA_WIDTH      = 4,
    parameter int unsigned REGFILE_R_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dp_reg_write,
    input  logic [REGFILE_WIDTH-1:0] dp_write_reg,
    input  logic [DATA_WIDTH-1:0]    dp_write_data,
    input  logic [REGFILE_WIDTH-1:0] dp_read_reg,
    input  logic                     dump_start,
    input  logic [DATA_WIDTH-1:0]    rf_read_data,
    output logic                     rf_reg_write,
    output logic [REGFILE_WIDTH-1:0] rf_write_reg,
    output logic [DATA_WIDTH-1:0]    rf_write_data,
    output logic [REGFILE_WIDTH-1:0] rf_read_reg,
    output logic                     ready,
    output logic                     dump_valid,
    output logic [REGFILE_WIDTH-1:0] dump_index,
    output logic [DATA_WIDTH-1:0]    dump_data
);

    localparam int unsigned RW = REGFILE_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam logic [RW-1:0] LAST_IDX = RW'(REGFILE_R_WIDTH - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        DUMP  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [RW-1:0]   idx, idx_next;
    logic            ready_next;
    logic            dump_valid_next;
    logic [RW-1:0]   dump_index_next;
    logic [DW-1:0]   dump_data_next;

    // State, shared counter and registered dump/ready outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            idx        <= '0;
            ready      <= 1'b0;
            dump_valid <= 1'b0;
            dump_index <= '0;
            dump_data  <= '0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            ready      <= ready_next;
            dump_valid <= dump_valid_next;
            dump_index <= dump_index_next;
            dump_data  <= dump_data_next;
        end
    end

    // Next-state logic plus the combinational register-file port drive
    always_comb begin
        state_next      = state;
        idx_next        = idx;
        ready_next      = ready;
        dump_valid_next = 1'b0;
        dump_index_next = dump_index;
        dump_data_next  = dump_data;
        rf_reg_write    = dp_reg_write;
        rf_write_reg    = dp_write_reg;
        rf_write_data   = dp_write_data;
        rf_read_reg     = dp_read_reg;

        unique case (state)
            CLEAR: begin
                // Datapath writes are dropped until every register is zeroed
                rf_reg_write  = 1'b1;
                rf_write_reg  = idx;
                rf_write_data = '0;
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    ready_next = 1'b1;
                end else begin
                    idx_next = idx + RW'(1);
                end
            end
            IDLE: begin
                if (dump_start) begin
                    state_next = DUMP;
                    idx_next   = '0;
                end
            end
            DUMP: begin
                // Read happens before the edge, so a same-cycle write reports the old value
                rf_read_reg     = idx;
                dump_valid_next = 1'b1;
                dump_index_next = idx;
                dump_data_next  = rf_read_data;
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + RW'(1);
                end
            end
            default: begin
                state_next = CLEAR;
                idx_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register file attached.
module tb_regfile_sequencer;

    localparam int unsigned RW = 3;
    localparam int unsigned DW = 4;
    localparam int unsigned NR = 8;

    logic          clock;
    logic          reset;
    logic          dp_reg_write;
    logic [RW-1:0] dp_write_reg;
    logic [DW-1:0] dp_write_data;
    logic [RW-1:0] dp_read_reg;
    logic          dump_start;
    logic [DW-1:0] rf_read_data;
    logic          rf_reg_write;
    logic [RW-1:0] rf_write_reg;
    logic [DW-1:0] rf_write_data;
    logic [RW-1:0] rf_read_reg;
    logic          ready;
    logic          dump_valid;
    logic [RW-1:0] dump_index;
    logic [DW-1:0] dump_data;

    regfile_sequencer #(
        .REGFILE_WIDTH  (RW),
        .DATA_WIDTH     (DW),
        .REGFILE_R_WIDTH(NR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dp_reg_write (dp_reg_write),
        .dp_write_reg (dp_write_reg),
        .dp_write_data(dp_write_data),
        .dp_read_reg  (dp_read_reg),
        .dump_start   (dump_start),
        .rf_read_data (rf_read_data),
        .rf_reg_write (rf_reg_write),
        .rf_write_reg (rf_write_reg),
        .rf_write_data(rf_write_data),
        .rf_read_reg  (rf_read_reg),
        .ready        (ready),
        .dump_valid   (dump_valid),
        .dump_index   (dump_index),
        .dump_data    (dump_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file without reset: synchronous write, combinational read port 1
    logic [DW-1:0] rf_mem [NR];
    always @(posedge clock) begin
        if (rf_reg_write) rf_mem[rf_write_reg] <= rf_write_data;
    end
    assign rf_read_data = rf_mem[rf_read_reg];

    int checks;
    int failures;
    logic [DW-1:0] exp_dump [NR];

    typedef struct {
        logic          we;
        logic [RW-1:0] wreg;
        logic [DW-1:0] wdata;
        logic [RW-1:0] rreg;
        logic          ex_we;
        logic [RW-1:0] ex_wreg;
        logic [DW-1:0] ex_wdata;
        logic [RW-1:0] ex_rreg;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expects eight zero-writes to indices 0..7, then ready high
    task automatic run_clear();
        for (int i = 0; i < int'(NR); i++) begin
            chk("clear_we", 32'(rf_reg_write), 32'(1));
            chk("clear_reg", 32'(rf_write_reg), 32'(i));
            chk("clear_data", 32'(rf_write_data), 32'(0));
            chk("clear_ready", 32'(ready), 32'(0));
            @(negedge clock);
        end
        chk("ready_after_clear", 32'(ready), 32'(1));
    endtask

    // Full dump against exp_dump; optional write to r2 at step wr_k, optional reset at step abort_k
    task automatic run_dump(input int wr_k, input int abort_k);
        dump_start  = 1'b1;
        dp_read_reg = 3'd6;
        @(negedge clock);
        chk("dump_valid_start", 32'(dump_valid), 32'(0));
        for (int k = 0; k <= int'(NR); k++) begin
            if (k == 3) dump_start = 1'b0;
            if (k == wr_k) begin
                dp_reg_write  = 1'b1;
                dp_write_reg  = 3'd2;
                dp_write_data = 4'h7;
            end else begin
                dp_reg_write = 1'b0;
            end
            #1;
            if (k < int'(NR)) chk("dump_rd_addr", 32'(rf_read_reg), 32'(k));
            if (k == wr_k) begin
                chk("dump_wr_pass_we", 32'(rf_reg_write), 32'(1));
                chk("dump_wr_pass_reg", 32'(rf_write_reg), 32'(2));
                chk("dump_wr_pass_data", 32'(rf_write_data), 32'(7));
            end
            if (k > 0) begin
                chk("dump_valid", 32'(dump_valid), 32'(1));
                chk("dump_index", 32'(dump_index), 32'(k - 1));
                chk("dump_data", 32'(dump_data), 32'(exp_dump[k-1]));
            end
            if (k == abort_k) begin
                reset = 1'b1;
                #1;
                chk("abort_valid", 32'(dump_valid), 32'(0));
                chk("abort_ready", 32'(ready), 32'(0));
                chk("abort_index", 32'(dump_index), 32'(0));
                chk("abort_data", 32'(dump_data), 32'(0));
                chk("abort_clear_we", 32'(rf_reg_write), 32'(1));
                chk("abort_clear_reg", 32'(rf_write_reg), 32'(0));
                return;
            end
            @(negedge clock);
        end
        dp_reg_write = 1'b0;
        chk("dump_valid_end", 32'(dump_valid), 32'(0));
        chk("idle_rd_pass", 32'(rf_read_reg), 32'(6));
        chk("ready_hold", 32'(ready), 32'(1));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        dp_reg_write  = 1'b0;
        dp_write_reg  = '0;
        dp_write_data = '0;
        dp_read_reg   = '0;
        dump_start    = 1'b0;
        for (int i = 0; i < int'(NR); i++) rf_mem[i] = 4'h5;

        vecs[0] = '{1'b1, 3'd3, 4'hA, 3'd1, 1'b1, 3'd3, 4'hA, 3'd1};
        vecs[1] = '{1'b0, 3'd6, 4'h5, 3'd7, 1'b0, 3'd6, 4'h5, 3'd7};
        vecs[2] = '{1'b1, 3'd7, 4'hC, 3'd3, 1'b1, 3'd7, 4'hC, 3'd3};
        vecs[3] = '{1'b0, 3'd2, 4'h9, 3'd0, 1'b0, 3'd2, 4'h9, 3'd0};

        // Reset values
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_ready", 32'(ready), 32'(0));
        chk("rst_valid", 32'(dump_valid), 32'(0));
        chk("rst_index", 32'(dump_index), 32'(0));
        chk("rst_data", 32'(dump_data), 32'(0));

        // Clear sequence with a datapath write to r5 that must be dropped
        dp_reg_write  = 1'b1;
        dp_write_reg  = 3'd5;
        dp_write_data = 4'hF;
        reset         = 1'b0;
        run_clear();
        dp_reg_write = 1'b0;

        // IDLE pass-through table
        for (int v = 0; v < 4; v++) begin
            dp_reg_write  = vecs[v].we;
            dp_write_reg  = vecs[v].wreg;
            dp_write_data = vecs[v].wdata;
            dp_read_reg   = vecs[v].rreg;
            #1;
            chk("pass_we", 32'(rf_reg_write), 32'(vecs[v].ex_we));
            chk("pass_reg", 32'(rf_write_reg), 32'(vecs[v].ex_wreg));
            chk("pass_data", 32'(rf_write_data), 32'(vecs[v].ex_wdata));
            chk("pass_rd", 32'(rf_read_reg), 32'(vecs[v].ex_rreg));
            @(negedge clock);
        end
        dp_reg_write = 1'b0;

        // r3=A, r7=C, r5 still zero after the dropped clear-time write
        for (int i = 0; i < int'(NR); i++) exp_dump[i] = 4'h0;
        exp_dump[3] = 4'hA;
        exp_dump[7] = 4'hC;
        run_dump(-1, -1);

        // r_i = i+8 for all registers
        for (int i = 0; i < int'(NR); i++) begin
            dp_reg_write  = 1'b1;
            dp_write_reg  = RW'(i);
            dp_write_data = DW'(i + 8);
            #1;
            chk("fill_data", 32'(rf_write_data), 32'(i + 8));
            @(negedge clock);
        end
        dp_reg_write = 1'b0;
        for (int i = 0; i < int'(NR); i++) exp_dump[i] = DW'(i + 8);
        run_dump(-1, -1);

        // Same-cycle write to r2 while it is being dumped: old value reported, new kept
        run_dump(2, -1);
        exp_dump[2] = 4'h7;
        run_dump(-1, -1);

        // Reset while dump_index 4 is shown, then a full re-clear
        run_dump(-1, 5);
        @(negedge clock);
        reset = 1'b0;
        run_clear();
        for (int i = 0; i < int'(NR); i++) exp_dump[i] = 4'h0;
        run_dump(-1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
